// File: rtl/imem_pkg.sv
// Shared sizes, state encoding and write-port payload for the instruction-memory boot loader.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH  = 1024;
    localparam int unsigned IMEM_ADDR_W = 10;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LEN_W       = 16;

    localparam logic [2:0] IDLE_ENC   = 3'd0;
    localparam logic [2:0] LEN_LO_ENC = 3'd1;
    localparam logic [2:0] LEN_HI_ENC = 3'd2;
    localparam logic [2:0] DATA_ENC   = 3'd3;
    localparam logic [2:0] WRITE_ENC  = 3'd4;
    localparam logic [2:0] DONE_ENC   = 3'd5;
    localparam logic [2:0] ERR_ENC    = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = IDLE_ENC,
        LEN_LO = LEN_LO_ENC,
        LEN_HI = LEN_HI_ENC,
        DATA   = DATA_ENC,
        WRITE  = WRITE_ENC,
        DONE   = DONE_ENC,
        ERR    = ERR_ENC
    } state_e;

    typedef struct packed {
        logic                   we;
        logic [IMEM_ADDR_W-1:0] waddr;
        logic [WORD_W-1:0]      wdata;
    } imem_wr_t;

endpackage

// File: rtl/imem_word_packer.sv
// Shifts little-endian bytes into a 32-bit word; flags the byte that completes a word.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next_c,
    output logic              word_ready_c
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        cnt_q;

    // Newest byte enters at the top so byte0 ends up in [7:0] after four shifts.
    assign word_next_c  = {byte_in, word_q[WORD_W-1:BYTE_W]};
    assign word_ready_c = shift_en && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            word_q <= word_next_c;
            cnt_q  <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed byte image and writes it word by word into
// instruction memory, holding the core in reset until the whole image is in place.
module imem_loader
    import imem_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [BYTE_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   we,
    output logic [IMEM_ADDR_W-1:0] waddr,
    output logic [WORD_W-1:0]      wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   cpu_reset
);

    localparam int unsigned DEPTH  = IMEM_DEPTH;
    localparam int unsigned ADDR_W = IMEM_ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned CMP_W  = LEN_W + 1;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  k_q, k_d;
    imem_wr_t          wr_q, wr_d;
    logic              in_ready_d, busy_d, done_d, error_d, cpu_reset_d;

    logic              xfer;
    logic              pk_clear;
    logic              pk_shift;
    logic [WORD_W-1:0] pk_word_next_c;
    logic              pk_word_ready_c;

    assign xfer = in_valid && in_ready;

    imem_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (pk_clear),
        .shift_en     (pk_shift),
        .byte_in      (in_data),
        .word_next_c  (pk_word_next_c),
        .word_ready_c (pk_word_ready_c)
    );

    // Next state, counters and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        k_d         = k_q;
        wr_d        = wr_q;
        wr_d.we     = 1'b0;
        pk_clear    = 1'b0;
        pk_shift    = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = LEN_LO;
                    k_d      = '0;
                    pk_clear = 1'b1;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = {in_data, len_lo_q};
                    if (len_d == '0) begin
                        state_d = DONE;
                    end else if (CMP_W'(len_d) > CMP_W'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                pk_shift = xfer;
                if (pk_word_ready_c) begin
                    state_d  = WRITE;
                    wr_d.we    = 1'b1;
                    wr_d.waddr = k_q[ADDR_W-1:0];
                    wr_d.wdata = pk_word_next_c;
                end
            end
            WRITE: begin
                if (LEN_W'(k_q) + LEN_W'(1) == len_q) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + CNT_W'(1);
                    state_d = DATA;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
        busy_d      = in_ready_d || (state_d == WRITE);
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERR);
        cpu_reset_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            len_lo_q  <= '0;
            len_q     <= '0;
            k_q       <= '0;
            wr_q      <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            k_q       <= k_d;
            wr_q      <= wr_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            cpu_reset <= cpu_reset_d;
        end
    end

    assign we    = wr_q.we;
    assign waddr = wr_q.waddr;
    assign wdata = wr_q.wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for the instruction-memory boot loader.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, we, busy, done, error, cpu_reset;
    logic [9:0]  waddr;
    logic [31:0] wdata;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0]  wa_log[$];
    logic [31:0] wd_log[$];

    logic [7:0]  img [14] = '{8'h03, 8'h00,
                              8'h93, 8'h02, 8'h40, 8'h00,
                              8'h13, 8'h03, 8'h60, 8'h00,
                              8'h33, 8'h84, 8'h62, 8'h00};
    logic [31:0] img_words [3] = '{32'h00400293, 32'h00600313, 32'h00628433};

    always #5 clk = ~clk;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_reset (cpu_reset)
    );

    // Record every write pulse seen on the memory port.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_log.push_back(waddr);
            wd_log.push_back(wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic clear_log();
        wa_log.delete();
        wd_log.delete();
    endtask

    task automatic check_image_log(input string tag);
        #1;
        check({tag, "_count"}, 32'(wa_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < wa_log.size(); i++) begin
            check({tag, "_addr"}, 32'(wa_log[i]), 32'(i));
            check({tag, "_data"}, wd_log[i], img_words[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_we"},        32'(we),        32'd0);
        check({tag, "_waddr"},     32'(waddr),     32'd0);
        check({tag, "_wdata"},     wdata,          32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_error"},     32'(error),     32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;

        // 1: three-word image, back to back
        clear_log();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_cpu_reset_hold", 32'(cpu_reset), 32'd1);
        for (int i = 0; i < 14; i++) send_byte(img[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_we", 32'(we), 32'd1);
        check("t1_waddr", 32'(waddr), 32'd2);
        check("t1_wdata", wdata, 32'h00628433);
        check("t1_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t1_we_off", 32'(we), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_wdata_hold", wdata, 32'h00628433);
        check_image_log("t1_log");

        // 2: empty image
        clear_log();
        pulse_start();
        check("t2_done_clr", 32'(done), 32'd0);
        check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu_reset_rel", 32'(cpu_reset), 32'd0);
        #1;
        check("t2_no_we", 32'(wa_log.size()), 32'd0);

        // 3: oversize length
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t3_error", 32'(error), 32'd1);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        #1;
        check("t3_no_we", 32'(wa_log.size()), 32'd0);
        pulse_start();
        check("t3_error_clr", 32'(error), 32'd0);
        check("t3_relaunch", 32'(in_ready), 32'd1);

        // 4: same image with random valid gaps
        clear_log();
        for (int i = 0; i < 14; i++) send_byte(img[i], int'($urandom_range(0, 3)));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_done", 32'(done), 32'd1);
        check_image_log("t4_log");

        // 5: reset in the middle of word 1
        clear_log();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(img[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        check("t5_one_write", 32'(wa_log.size()), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_still_one_write", 32'(wa_log.size()), 32'd1);
        clear_log();
        pulse_start();
        for (int i = 0; i < 14; i++) send_byte(img[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_done", 32'(done), 32'd1);
        check_image_log("t5_log");

        // 6: start ignored mid-load, then reload from DONE
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pulse_start();
        check("t6_ign_busy", 32'(busy), 32'd1);
        check("t6_ign_ready", 32'(in_ready), 32'd1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_we", 32'(we), 32'd1);
        check("t6_waddr", 32'(waddr), 32'd0);
        check("t6_wdata", wdata, 32'h44332211);
        @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        pulse_start();
        check("t6_reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t6_reload_done", 32'(done), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hef, 0);
        send_byte(8'hbe, 0);
        send_byte(8'had, 0);
        send_byte(8'hde, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_reload_we", 32'(we), 32'd1);
        check("t6_reload_waddr", 32'(waddr), 32'd0);
        check("t6_reload_wdata", wdata, 32'hdeadbeef);
        @(negedge clk);
        check("t6_reload_done2", 32'(done), 32'd1);
        check("t6_reload_cpu_rel", 32'(cpu_reset), 32'd0);
        #1;
        check("t6_write_count", 32'(wa_log.size()), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
